// File: rtl/cnn_core_seq_pkg.sv
// cnn_core_seq shared definitions.
// State encoding and parameter defaults.
package cnn_core_seq_pkg;

  localparam int CNT_BW_D       = 16;
  localparam int RD_LAT_D       = 1;
  localparam int MAX_INFLIGHT_D = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/cnn_seq_credit.sv
// cnn_seq_credit: in-flight window counter.
// Full/empty flags and underflow detect.
module cnn_seq_credit
  import cnn_core_seq_pkg::*;
#(
  parameter int MAX = MAX_INFLIGHT_D,
  localparam int IW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  input  logic dec,
  input  logic ret,
  output logic full,
  output logic empty,
  output logic err
);

  logic [IW-1:0] cnt;

  assign full  = (cnt == IW'(MAX));
  assign empty = (cnt == '0);
  assign err   = ret && empty;

  // issue adds a credit use, accepted return releases one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + IW'(issue) - IW'(dec);
    end
  end

endmodule

// File: rtl/cnn_core_seq.sv
// cnn_core_seq: run-level sequencer for cnn_core.
// Soft reset, window reads, result addressing.
module cnn_core_seq
  import cnn_core_seq_pkg::*;
#(
  parameter int CNT_BW       = CNT_BW_D,
  parameter int RD_LAT       = RD_LAT_D,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [CNT_BW-1:0] i_num_win,
  output logic              o_idle,
  output logic              o_running,
  output logic              o_done,
  output logic              o_err,
  output logic              o_soft_reset,
  output logic              o_rd_en,
  output logic [CNT_BW-1:0] o_rd_addr,
  output logic              o_core_in_valid,
  input  logic              i_core_ot_valid,
  output logic              o_wr_en,
  output logic [CNT_BW-1:0] o_wr_addr
);

  state_t            state;
  logic [CNT_BW-1:0] num;
  logic [CNT_BW-1:0] issue_cnt;
  logic [CNT_BW-1:0] recv_cnt;
  logic [RD_LAT-1:0] dly;
  logic              full;
  logic              empty;
  logic              underflow;
  logic              rd_en;
  logic              wr_en;
  logic              last_issue;
  logic              last_recv;

  assign wr_en = i_core_ot_valid && !empty;

  // credit check uses post-decrement inflight
  assign rd_en = (state == S_RUN)
              && (issue_cnt < num)
              && (!full || wr_en);

  assign last_issue = rd_en
                   && (issue_cnt + CNT_BW'(1) == num);
  assign last_recv  = wr_en
                   && (recv_cnt + CNT_BW'(1) == num);

  cnn_seq_credit #(
    .MAX (MAX_INFLIGHT)
  ) u_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .issue   (rd_en),
    .dec     (wr_en),
    .ret     (i_core_ot_valid),
    .full    (full),
    .empty   (empty),
    .err     (underflow)
  );

  // run FSM with issue/receive counters and sticky error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      num       <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      o_err     <= 1'b0;
    end else begin
      if (rd_en) issue_cnt <= issue_cnt + CNT_BW'(1);
      if (wr_en) recv_cnt <= recv_cnt + CNT_BW'(1);
      unique case (state)
        S_IDLE: begin
          if (i_run) begin
            o_err     <= 1'b0;
            num       <= i_num_win;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= (i_num_win != '0) ? S_CLR : S_DONE;
          end
        end
        S_CLR:   state <= S_RUN;
        S_RUN:   if (last_issue) state <= S_DRAIN;
        S_DRAIN: if (last_recv) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (underflow) o_err <= 1'b1;
    end
  end

  // read-latency delay line from rd_en to core input valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dly <= '0;
    end else begin
      dly[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign o_idle          = (state == S_IDLE);
  assign o_running       = (state == S_CLR)
                        || (state == S_RUN)
                        || (state == S_DRAIN);
  assign o_done          = (state == S_DONE);
  assign o_soft_reset    = (state == S_CLR);
  assign o_rd_en         = rd_en;
  assign o_rd_addr       = issue_cnt;
  assign o_core_in_valid = dly[RD_LAT-1];
  assign o_wr_en         = wr_en;
  assign o_wr_addr       = recv_cnt;

endmodule

// File: tb/tb_cnn_core_seq.sv
// tb_cnn_core_seq: directed bench for cnn_core_seq.
// Two instances: default credits and MAX_INFLIGHT=2.
module tb_cnn_core_seq;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        run_a, run_b;
  logic [15:0] num_a, num_b;
  logic        idle_a, idle_b;
  logic        running_a, running_b;
  logic        done_a, done_b;
  logic        err_a, err_b;
  logic        soft_a, soft_b;
  logic        rd_a, rd_b;
  logic [15:0] rdaddr_a, rdaddr_b;
  logic        inv_a, inv_b;
  logic        ot_a, ot_b;
  logic        wr_a, wr_b;
  logic [15:0] wraddr_a, wraddr_b;
  logic        spur_a;

  logic [1:0]  pa;
  logic [5:0]  pb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cnn_core_seq u_dut_a (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_run           (run_a),
    .i_num_win       (num_a),
    .o_idle          (idle_a),
    .o_running       (running_a),
    .o_done          (done_a),
    .o_err           (err_a),
    .o_soft_reset    (soft_a),
    .o_rd_en         (rd_a),
    .o_rd_addr       (rdaddr_a),
    .o_core_in_valid (inv_a),
    .i_core_ot_valid (ot_a),
    .o_wr_en         (wr_a),
    .o_wr_addr       (wraddr_a)
  );

  cnn_core_seq #(
    .MAX_INFLIGHT (2)
  ) u_dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_run           (run_b),
    .i_num_win       (num_b),
    .o_idle          (idle_b),
    .o_running       (running_b),
    .o_done          (done_b),
    .o_err           (err_b),
    .o_soft_reset    (soft_b),
    .o_rd_en         (rd_b),
    .o_rd_addr       (rdaddr_b),
    .o_core_in_valid (inv_b),
    .i_core_ot_valid (ot_b),
    .o_wr_en         (wr_b),
    .o_wr_addr       (wraddr_b)
  );

  // core models: latency 2 for a, latency 6 for b
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pa <= '0;
      pb <= '0;
    end else begin
      pa <= {pa[0], inv_a};
      pb <= {pb[4:0], inv_b};
    end
  end

  assign ot_a = pa[1] | spur_a;
  assign ot_b = pb[5];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string p);
    chk({p, "_idle"}, 32'(idle_a), 32'd1);
    chk({p, "_running"}, 32'(running_a), 32'd0);
    chk({p, "_done"}, 32'(done_a), 32'd0);
    chk({p, "_err"}, 32'(err_a), 32'd0);
    chk({p, "_soft"}, 32'(soft_a), 32'd0);
    chk({p, "_rd_en"}, 32'(rd_a), 32'd0);
    chk({p, "_rd_addr"}, 32'(rdaddr_a), 32'd0);
    chk({p, "_in_valid"}, 32'(inv_a), 32'd0);
    chk({p, "_wr_en"}, 32'(wr_a), 32'd0);
    chk({p, "_wr_addr"}, 32'(wraddr_a), 32'd0);
  endtask

  // full run on a (RD_LAT 1, core latency 2): cycle c after i_run
  task automatic run_a_n(input string p, input int n);
    @(negedge clk);
    run_a = 1'b1;
    num_a = 16'(n);
    for (int c = 1; c <= n + 6; c++) begin
      @(negedge clk);
      run_a = 1'b0;
      chk({p, "_soft"}, 32'(soft_a), 32'(c == 1));
      chk({p, "_rd_en"}, 32'(rd_a),
          32'(c >= 2 && c <= n + 1));
      if (c >= 2 && c <= n + 1)
        chk({p, "_rd_addr"}, 32'(rdaddr_a), 32'(c - 2));
      chk({p, "_in_valid"}, 32'(inv_a),
          32'(c >= 3 && c <= n + 2));
      chk({p, "_wr_en"}, 32'(wr_a),
          32'(c >= 5 && c <= n + 4));
      if (c >= 5 && c <= n + 4)
        chk({p, "_wr_addr"}, 32'(wraddr_a), 32'(c - 5));
      chk({p, "_done"}, 32'(done_a), 32'(c == n + 5));
    end
    chk({p, "_idle_end"}, 32'(idle_a), 32'd1);
  endtask

  initial begin
    int nr, nw, nd, bi, iss;
    logic exp_wr, exp_rd;

    reset_n = 1'b0;
    run_a = 1'b0; num_a = '0; spur_a = 1'b0;
    run_b = 1'b0; num_b = '0;
    repeat (2) @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_idle", 32'(idle_b), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // basic run, num=4
    run_a_n("basic", 4);

    // num=0
    @(negedge clk);
    run_a = 1'b1;
    num_a = 16'd0;
    @(negedge clk);
    run_a = 1'b0;
    chk("zero_done", 32'(done_a), 32'd1);
    chk("zero_soft", 32'(soft_a), 32'd0);
    chk("zero_rd_en", 32'(rd_a), 32'd0);
    chk("zero_running", 32'(running_a), 32'd0);
    @(negedge clk);
    chk("zero_done_end", 32'(done_a), 32'd0);
    chk("zero_idle", 32'(idle_a), 32'd1);
    chk("zero_wr_en", 32'(wr_a), 32'd0);

    // spurious result in IDLE
    @(negedge clk);
    spur_a = 1'b1;
    #1;
    chk("spur_wr_en", 32'(wr_a), 32'd0);
    @(negedge clk);
    spur_a = 1'b0;
    chk("spur_err", 32'(err_a), 32'd1);
    @(negedge clk);
    chk("spur_err_sticky", 32'(err_a), 32'd1);

    // i_run mid-RUN ignored, also clears err on accept
    run_a = 1'b1;
    num_a = 16'd3;
    nr = 0; nw = 0; nd = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      run_a = (c == 3);
      num_a = (c == 3) ? 16'd7 : 16'd3;
      if (c == 1) chk("mid_err_clr", 32'(err_a), 32'd0);
      #1;
      if (rd_a) begin
        chk("mid_rd_addr", 32'(rdaddr_a), 32'(nr));
        nr++;
      end
      if (wr_a) begin
        chk("mid_wr_addr", 32'(wraddr_a), 32'(nw));
        nw++;
      end
      if (done_a) nd++;
    end
    run_a = 1'b0;
    chk("mid_reads", 32'(nr), 32'd3);
    chk("mid_writes", 32'(nw), 32'd3);
    chk("mid_dones", 32'(nd), 32'd1);

    // credit stall on b: MAX_INFLIGHT=2, core latency 6
    @(negedge clk);
    run_b = 1'b1;
    num_b = 16'd5;
    bi = 0; iss = 0; nw = 0; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      run_b = 1'b0;
      exp_wr = ot_b && (bi > 0);
      exp_rd = (c >= 2) && (iss < 5)
            && ((bi - int'(exp_wr)) < 2);
      chk("cr_wr_en", 32'(wr_b), 32'(exp_wr));
      chk("cr_rd_en", 32'(rd_b), 32'(exp_rd));
      if (rd_b) begin
        chk("cr_rd_addr", 32'(rdaddr_b), 32'(iss));
        iss++;
        bi++;
      end
      if (wr_b) begin
        chk("cr_wr_addr", 32'(wraddr_b), 32'(nw));
        nw++;
        bi--;
      end
      chk("cr_inflight_le2", 32'(bi <= 2), 32'd1);
      if (done_b) nd++;
    end
    chk("cr_reads", 32'(iss), 32'd5);
    chk("cr_writes", 32'(nw), 32'd5);
    chk("cr_dones", 32'(nd), 32'd1);
    chk("cr_err", 32'(err_b), 32'd0);

    // async reset in DRAIN with 2 in flight
    @(negedge clk);
    run_a = 1'b1;
    num_a = 16'd4;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      run_a = 1'b0;
    end
    chk("ar_running", 32'(running_a), 32'd1);
    chk("ar_rd_en", 32'(rd_a), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_a("ar");
    @(negedge clk);
    reset_n = 1'b1;
    run_a_n("post_rst", 2);
    chk("post_rst_err", 32'(err_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnn_core_seq.md
Name: cnn_core_seq

Overview:
- Run-level sequencer for cnn_core.
- On a start pulse it clears the core with a soft reset, then issues N window reads to the input-fmap buffer, turning each returned window into a core input-valid pulse.
- Counts core results, generates sequential write addresses for the output-fmap buffer, and reports done.
- Bounds in-flight windows with a credit counter so the downstream result buffer cannot overflow.

Parameters:
- CNT_BW, 16, width of window count, issue/receive counters and buffer addresses.
- RD_LAT, 1, fixed read latency (cycles) of the input-fmap buffer, >=1.
- MAX_INFLIGHT, 8, max windows issued but not yet returned by core (>=1, <=255).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_num_win  in  CNT_BW  number of windows for this run; latched on accepted i_run.
- o_idle  out  1  high in IDLE.
- o_running  out  1  high in CLR, RUN, DRAIN.
- o_done  out  1  one-cycle pulse at end of run.
- o_err  out  1  sticky; set when i_core_ot_valid arrives with no window in flight; cleared on accepted i_run.
- o_soft_reset  out  1  to core i_soft_reset; high exactly one cycle (CLR).
- o_rd_en  out  1  input-fmap buffer read enable.
- o_rd_addr  out  CNT_BW  window index being read.
- o_core_in_valid  out  1  to core i_in_valid; o_rd_en delayed RD_LAT cycles.
- i_core_ot_valid  in  1  from core o_ot_valid.
- o_wr_en  out  1  output-fmap buffer write enable (= i_core_ot_valid while in flight, combinational).
- o_wr_addr  out  CNT_BW  result index (= receive counter).

Behaviour:
- Reset: state IDLE. All counters 0. Delay line cleared.
- Reset values: o_idle=1, o_running=0, o_done=0, o_err=0, o_soft_reset=0, o_rd_en=0, o_rd_addr=0, o_core_in_valid=0, o_wr_en=0, o_wr_addr=0.
- States: IDLE, CLR, RUN, DRAIN, DONE; encoding is internal.
- IDLE, i_run=1, i_num_win!=0: latch num, clear issue_cnt, recv_cnt and o_err, go to CLR.
- IDLE, i_run=1, i_num_win=0: clear o_err, go to DONE; no reads, no soft reset.
- CLR: o_soft_reset=1 for one cycle, go to RUN. No read is issued in CLR.
- RUN: o_rd_en=1 iff issue_cnt<num and inflight<MAX_INFLIGHT.
  - o_rd_addr = issue_cnt.
  - On issue, issue_cnt++ and inflight++.
  - When the final issue occurs (issue_cnt becomes num), next state is DRAIN.
- DRAIN: no reads. When recv_cnt==num, go to DONE.
- DONE: o_done=1 for one cycle, go to IDLE.
- i_run outside IDLE is ignored, including in DONE.
- Read path: o_core_in_valid(t+RD_LAT) = o_rd_en(t). The delay line is a shift register cleared by reset only.
- Result path: i_core_ot_valid while inflight>0 gives o_wr_en=1, o_wr_addr=recv_cnt, recv_cnt++, inflight--.
  - Same-cycle issue and receive leaves inflight unchanged.
  - i_core_ot_valid with inflight=0 gives no write and sets o_err; the counter does not underflow.
- Credit boundary: at inflight==MAX_INFLIGHT, rd_en is held low. It may reassert in the same cycle a result returns, because the credit check uses post-decrement inflight.
- Counter widths: inflight is ceil(log2(MAX_INFLIGHT+1)) bits. issue/recv counters are CNT_BW bits and never wrap, since num<=2^CNT_BW-1.
- Throughput: with an unrestricted core and MAX_INFLIGHT >= RD_LAT+core latency, one window per cycle.
  - Run time = 1 (CLR) + num + RD_LAT + core latency + 1 (DONE) cycles from i_run.
- Reset mid-run: all state asynchronously returns to reset values. Reads already in the delay line are dropped.

Decomposition:
- Shared package/header (alongside the core defines): state encodings, CNT_BW and MAX_INFLIGHT defaults, RD_LAT default.
- One sub-module: cnn_seq_credit, the inflight up/down counter with full/empty flags and the underflow-error output.
- The delay line and FSM stay in the top.

Test Plan:
- Basic run, RD_LAT=1, core latency 2, num=4: one o_soft_reset pulse at cycle 1; rd_addr 0..3 on cycles 2..5; core_in_valid on 3..6; wr_addr 0..3 on 5..8; o_done at cycle 9.
- num=0: o_done pulse 1 cycle after i_run; no soft_reset, rd_en or wr_en.
- Credit stall, MAX_INFLIGHT=2, core latency 6, num=5: at most 2 windows outstanding at any time; rd_en low while inflight==2; all 5 writes, addresses 0..4 in order; done once.
- Spurious result: i_core_ot_valid pulse in IDLE sets o_err=1 with o_wr_en=0; next accepted i_run clears o_err.
- i_run asserted mid-RUN (num=3, then num=7 offered): ignored; exactly 3 reads/writes, then done.
- Async reset asserted in DRAIN with 2 in flight: all outputs immediately at reset values; a subsequent run of num=2 completes normally with wr_addr 0,1.
